// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone memory arbiter and its picker.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin request picker: first requester scanning upward from last+1 modulo NM.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
//
// Ports:
//   req  - one bit per requester
//   last - index served most recently (scan starts just after it)
//   pick - one-hot winner, all zero when nobody requests
//   idx  - encoded winner index, zero when nobody requests
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NM = 3,
  parameter int PW = clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] last,
  output logic [NM-1:0] pick,
  output logic [PW-1:0] idx
);

  logic          found;
  int            k;
  logic [PW-1:0] kk;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    // i runs 1..NM so the last-served index is considered only at the very end
    for (int i = 1; i <= NM; i++) begin
      k  = (int'(last) + i) % NM;
      kk = PW'(k);
      if (!found && req[kk]) begin
        found    = 1'b1;
        pick[kk] = 1'b1;
        idx      = kk;
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one memory slave between NM masters, with a bus watchdog.
// Latency: grant registered one cycle after cyc is seen in IDLE; data/ack path is combinational while BUSY.
// Backpressure: the granted master owns the slave until it drops cyc; other masters simply wait with cyc high.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        - clock, asynchronous active-low reset
//   m_*_i                       - packed master requests, master k at slice k
//   m_dat_o, m_ack_o, m_err_o   - read data broadcast, per-master ack/error
//   s_*_o, s_dat_i/ack_i/err_i  - single slave port
//   grant_o                     - one-hot current owner, zero when idle
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM*3-1:0]    m_cti_i,
  input  logic [NM*2-1:0]    m_bte_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  output logic               s_we_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  output logic [NM-1:0]      grant_o
);

  localparam int PW = clog2(NM);
  localparam int SW = DW / 8;
  localparam int WW = clog2(TIMEOUT + 1);

  arb_state_t    state;
  logic [PW-1:0] last;      // while BUSY this is also the granted index
  logic [WW-1:0] wd_cnt;
  logic [NM-1:0] pick;
  logic [PW-1:0] pick_idx;
  logic          busy;
  logic          stb_raw;
  logic          wd_fire;

  wb_rr_picker #(
    .NM (NM),
    .PW (PW)
  ) u_picker (
    .req  (m_cyc_i),
    .last (last),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign busy    = (state == BUSY);
  assign stb_raw = busy && m_cyc_i[last] && m_stb_i[last];
  // A real slave response in the same cycle wins over the watchdog
  assign wd_fire = (TIMEOUT != 0) && busy && (wd_cnt == WW'(TIMEOUT)) && !s_ack_i && !s_err_i;
  assign m_dat_o = s_dat_i;

  // Slave-side mux and response routing; everything is zero unless BUSY,
  // so an asynchronous reset kills the cycle without waiting for a clock.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      s_adr_o       = m_adr_i[int'(last)*AW +: AW];
      s_dat_o       = m_dat_i[int'(last)*DW +: DW];
      s_sel_o       = m_sel_i[int'(last)*SW +: SW];
      s_we_o        = m_we_i[last];
      s_cyc_o       = m_cyc_i[last];
      s_stb_o       = stb_raw && !wd_fire;
      s_cti_o       = m_cti_i[int'(last)*3 +: 3];
      s_bte_o       = m_bte_i[int'(last)*2 +: 2];
      m_ack_o[last] = s_ack_i;
      m_err_o[last] = s_err_i || wd_fire;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state   <= IDLE;
      grant_o <= '0;
      last    <= PW'(NM - 1);   // master 0 wins the first arbitration
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|m_cyc_i) begin
            state   <= BUSY;
            grant_o <= pick;
            last    <= pick_idx;
          end
        end
        BUSY: begin
          if (!m_cyc_i[last]) begin
            // Always pass through IDLE so owners are separated by a dead slave cycle
            state   <= IDLE;
            grant_o <= '0;
            wd_cnt  <= '0;
          end else if (TIMEOUT == 0 || !stb_raw || s_ack_i || s_err_i || wd_fire) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
Round-robin Wishbone B3 arbiter that shares the single on-chip memory slave (wb_bfm_memory) between NM masters: CPU instruction bus, CPU data bus and debug interface. It sits in orpsoc_top between the masters and the memory. It holds grant for a whole cycle, so bursts and locked sequences are atomic. A bus watchdog terminates stalled transfers with an error.

Parameters:
NM, 3, number of masters; index 0 = ibus, 1 = dbus, 2 = debug
AW, 32, address width
DW, 32, data width; select width is DW/8
TIMEOUT, 255, cycles of unacknowledged stb before watchdog error; 0 disables watchdog

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  asynchronous active-low reset
m_adr_i  in  NM*AW  master addresses, master k at bits [k*AW +: AW]
m_dat_i  in  NM*DW  master write data
m_sel_i  in  NM*DW/8  master byte selects
m_we_i  in  NM  master write enables
m_cyc_i  in  NM  master cycle
m_stb_i  in  NM  master strobe
m_cti_i  in  NM*3  master cycle type
m_bte_i  in  NM*2  master burst type
m_dat_o  out  DW  read data, broadcast to all masters
m_ack_o  out  NM  per-master ack
m_err_o  out  NM  per-master error
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte select
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_cti_o  out  3  slave cycle type
s_bte_o  out  2  slave burst type
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  NM  one-hot current grant; all zero when idle

Behaviour:
- Reset (async assert, sync release): state IDLE, grant_o = 0, last-served pointer = NM-1 so master 0 wins first, watchdog = 0. All s_* and m_ack_o/m_err_o are 0.
- State IDLE:
  - If any m_cyc_i is high, pick the first requester scanning from last+1 modulo NM.
  - Register the pick into grant_o, update last, and go to BUSY.
  - Arbitration latency: s_cyc_o rises the cycle after m_cyc_i rises.
- State BUSY:
  - The s_* outputs are a combinational mux of the granted master's signals. s_cyc_o and s_stb_o are gated by the grant.
  - m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i, for the granted index g only. Non-granted acks and errors are 0.
  - m_dat_o = s_dat_i at all times.
  - Grant is held while m_cyc_i[g] is high, including stb-low gaps and CTI bursts.
- Leaving BUSY:
  - When m_cyc_i[g] falls, grant_o clears and the state returns to IDLE on the next edge.
  - This guarantees at least one idle slave cycle between owners; a new owner is granted one cycle later.
- Fairness:
  - A master that drops and immediately re-raises cyc yields to any other pending master.
  - With all masters requesting continuously, service order is 0, 1, 2, 0, and so on.
- Watchdog (TIMEOUT > 0):
  - The counter increments each BUSY cycle with s_stb_o high and neither s_ack_i nor s_err_i. It clears on ack, error, stb low or IDLE.
  - When the count reaches TIMEOUT, m_err_o[g] is pulsed for one cycle, s_stb_o is forced low that cycle, and the counter clears.
  - The master is expected to drop cyc.
- Simultaneous events: if cyc drops in the same cycle as s_ack_i, the ack is still routed (combinational). The new arbitration uses the already-updated last pointer.
- Reset mid-transfer: the grant is dropped immediately and asynchronously, s_cyc_o goes low, and no ack is routed.
- Ack, error and watchdog error are mutually exclusive per cycle; s_err_i has priority over a watchdog error in the same cycle.

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, BUSY}, CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111), a clog2 function for pointer width.
- Sub-module wb_rr_picker (combinational): inputs req[NM] and last index; outputs one-hot pick and encoded index. Reusable by other arbiters in orpsoc_top.

Test Plan:
- Single request: master 1 does a classic read at adr 0x100 and memory returns 0xDEADBEEF. Expected: s_cyc_o rises 1 cycle after m_cyc_i[1]; m_ack_o = 3'b010; m_dat_o = 0xDEADBEEF; grant_o returns to 0 one cycle after cyc drops.
- Simultaneous requests: all three raise cyc at reset release, each doing 2 single writes. Expected grant order 001, 010, 100, with exactly one idle slave cycle between owners.
- Burst hold: master 0 issues a 4-beat INCR burst (cti 010, 010, 010, 111) while master 2 requests. Expected: all 4 beats complete with grant 001 and no interleave, then grant 100.
- Watchdog: TIMEOUT=8, the slave never acks master 1's stb. Expected: m_err_o[1] pulses for exactly 1 cycle after 8 stalled cycles; no ack appears on any master.
- Slave error: s_err_i is asserted on master 2's write. Expected: m_err_o = 3'b100 in the same cycle and m_ack_o = 0.
- Async reset mid-burst: wb_rst_n_i goes low during beat 2. Expected: s_cyc_o = 0 and grant_o = 0 immediately (before the next edge); after release, master 0 is served first.
